// File: rtl/seq_detect_mealy.sv
// Mealy serial-pattern detector with a KMP-style automaton built from PATTERN at elaboration.
// y and d respond to x in the same cycle. n, match_count and count_sat are registered. Cycles with x_valid low are ignored.
module seq_detect_mealy #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 8,
  localparam int            SW      = $clog2(LEN)
) (
  input  logic             Clk_s,
  input  logic             Rst_s,
  input  logic             x_valid,
  input  logic             x,
  input  logic             mode_overlap,
  input  logic             clr_count,
  output logic [SW-1:0]    n,
  output logic [SW-1:0]    d,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int NS = 2 ** SW;

  // The longest proper pattern prefix that ends the stream "first k pattern bits, then b".
  // Bounding j at LEN-1 also gives the overlap restart state after a full match.
  function automatic int next_state(int k, logic b);
    logic [16:0] s;
    int          best;
    logic        ok;
    s    = '0;
    best = 0;
    if (k < LEN) begin
      for (int i = 0; i < k; i++) s[i] = PATTERN[LEN-1-i];
      s[k] = b;
      for (int j = 1; j < LEN; j++) begin
        if (j <= k + 1) begin
          ok = 1'b1;
          for (int i = 0; i < j; i++)
            if (PATTERN[LEN-1-i] != s[k+1-j+i]) ok = 1'b0;
          if (ok) best = j;
        end
      end
    end
    return best;
  endfunction

  localparam int             F_FULL  = next_state(LEN - 1, PATTERN[0]);
  localparam logic [SW-1:0]  LAST    = SW'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];

  // Unused encodings (k >= LEN) get a table value of 0.
  for (genvar k = 0; k < NS; k++) begin : g_tbl
    localparam int N0 = next_state(k, 1'b0);
    localparam int N1 = next_state(k, 1'b1);
    assign nxt0[k] = N0[SW-1:0];
    assign nxt1[k] = N1[SW-1:0];
  end

  always_comb begin
    d = '0;
    y = 1'b0;
    if (!Rst_s && int'(n) < LEN) begin
      if (!x_valid) begin
        d = n;
      end else if (n == LAST && x == PATTERN[0]) begin
        y = 1'b1;
        d = mode_overlap ? F_FULL[SW-1:0] : '0;
      end else begin
        d = x ? nxt1[n] : nxt0[n];
      end
    end
  end

  always_ff @(posedge Clk_s or posedge Rst_s) begin
    if (Rst_s) begin
      n           <= '0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      n <= d;
      if (clr_count) begin
        match_count <= y ? CNT_W'(1) : '0;
        count_sat   <= 1'b0;
      end else if (y) begin
        if (match_count != CNT_MAX) match_count <= match_count + 1'b1;
        // Flag goes up on the edge that reaches all-ones.
        if (match_count >= CNT_MAX - 1'b1) count_sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Directed bench for seq_detect_mealy: default 1011 detector, a 2-bit-counter copy
// and a 5-bit 11011 copy share one stimulus stream.
module tb_seq_detect_mealy;

  logic Clk_s, Rst_s, x_valid, x, mode_overlap, clr_count;

  logic [1:0] n_a, d_a;
  logic       y_a, sat_a;
  logic [7:0] cnt_a;
  logic [1:0] n_b, d_b;
  logic       y_b, sat_b;
  logic [1:0] cnt_b;
  logic [2:0] n_c, d_c;
  logic       y_c, sat_c;
  logic [7:0] cnt_c;

  int checks = 0;
  int errs   = 0;

  seq_detect_mealy u_a (
    .Clk_s(Clk_s), .Rst_s(Rst_s), .x_valid(x_valid), .x(x), .mode_overlap(mode_overlap),
    .clr_count(clr_count), .n(n_a), .d(d_a), .y(y_a), .match_count(cnt_a), .count_sat(sat_a)
  );

  seq_detect_mealy #(.CNT_W(2)) u_b (
    .Clk_s(Clk_s), .Rst_s(Rst_s), .x_valid(x_valid), .x(x), .mode_overlap(mode_overlap),
    .clr_count(clr_count), .n(n_b), .d(d_b), .y(y_b), .match_count(cnt_b), .count_sat(sat_b)
  );

  seq_detect_mealy #(.LEN(5), .PATTERN(5'b11011)) u_c (
    .Clk_s(Clk_s), .Rst_s(Rst_s), .x_valid(x_valid), .x(x), .mode_overlap(mode_overlap),
    .clr_count(clr_count), .n(n_c), .d(d_c), .y(y_c), .match_count(cnt_c), .count_sat(sat_c)
  );

  initial begin
    Clk_s = 1'b0;
    forever #10 Clk_s = ~Clk_s;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic ya, yb, yc;

  // Drive one bit at the falling edge, capture the Mealy outputs, then let the rising edge land.
  task automatic step(input logic v, input logic b, input logic clr);
    @(negedge Clk_s);
    x_valid   = v;
    x         = b;
    clr_count = clr;
    #2;
    ya = y_a;
    yb = y_b;
    yc = y_c;
    @(posedge Clk_s);
    #2;
  endtask

  task automatic do_reset();
    @(negedge Clk_s);
    Rst_s     = 1'b1;
    x_valid   = 1'b0;
    clr_count = 1'b0;
    #5;
    Rst_s = 1'b0;
  endtask

  task automatic test_reset();
    Rst_s = 1'b1; x_valid = 1'b1; x = 1'b1; mode_overlap = 1'b1; clr_count = 1'b0;
    #5;
    checks++; if (n_a !== 2'd0)   begin errs++; $display("FAIL rst_n got %0d want 0", n_a); end
    checks++; if (d_a !== 2'd0)   begin errs++; $display("FAIL rst_d got %0d want 0", d_a); end
    checks++; if (y_a !== 1'b0)   begin errs++; $display("FAIL rst_y got %b want 0", y_a); end
    checks++; if (cnt_a !== 8'd0) begin errs++; $display("FAIL rst_cnt got %0d want 0", cnt_a); end
    checks++; if (sat_a !== 1'b0) begin errs++; $display("FAIL rst_sat got %b want 0", sat_a); end
    #10;
    Rst_s = 1'b0;
    #1;
    checks++; if (d_a !== 2'd1)   begin errs++; $display("FAIL rel_d got %0d want 1", d_a); end
    x_valid = 1'b0;
  endtask

  task automatic test_stream32();
    logic [31:0] s;
    logic        ey;
    s = 32'b00001011001011111000010001010101;
    mode_overlap = 1'b1;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, s[31-i], 1'b0);
      ey = (i == 7 || i == 13);
      checks++; if (ya !== ey) begin errs++; $display("FAIL s32_y bit %0d got %b want %b", i, ya, ey); end
    end
    checks++; if (cnt_a !== 8'd2) begin errs++; $display("FAIL s32_cnt got %0d want 2", cnt_a); end
    checks++; if (n_a !== 2'd3)   begin errs++; $display("FAIL s32_n got %0d want 3", n_a); end
  endtask

  task automatic test_overlap();
    logic [6:0] s;
    logic       ey;
    logic [1:0] en;
    logic [7:0] ec;
    s = 7'b1011011;
    for (int ov = 1; ov >= 0; ov--) begin
      mode_overlap = ov[0];
      do_reset();
      for (int i = 0; i < 7; i++) begin
        step(1'b1, s[6-i], 1'b0);
        ey = ov[0] ? (i == 3 || i == 6) : (i == 3);
        checks++; if (ya !== ey) begin errs++; $display("FAIL ovl%0d_y bit %0d got %b want %b", ov, i, ya, ey); end
        if (i == 3) begin
          en = ov[0] ? 2'd1 : 2'd0;
          checks++; if (n_a !== en) begin errs++; $display("FAIL ovl%0d_n3 got %0d want %0d", ov, n_a, en); end
        end
      end
      ec = ov[0] ? 8'd2 : 8'd1;
      checks++; if (cnt_a !== ec) begin errs++; $display("FAIL ovl%0d_cnt got %0d want %0d", ov, cnt_a, ec); end
    end
  endtask

  task automatic test_gaps();
    logic [3:0] s;
    logic       ey;
    logic [1:0] en;
    s = 4'b1011;
    mode_overlap = 1'b1;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      step(1'b1, s[3-b], 1'b0);
      ey = (b == 3);
      checks++; if (ya !== ey) begin errs++; $display("FAIL gap_y bit %0d got %b want %b", b, ya, ey); end
      if (b < 3) begin
        en = 2'(b + 1);
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
          checks++; if (ya !== 1'b0) begin errs++; $display("FAIL gap_idle_y bit %0d got %b want 0", b, ya); end
          checks++; if (n_a !== en)  begin errs++; $display("FAIL gap_hold_n bit %0d got %0d want %0d", b, n_a, en); end
        end
      end
    end
    checks++; if (cnt_a !== 8'd1) begin errs++; $display("FAIL gap_cnt got %0d want 1", cnt_a); end
  endtask

  task automatic test_saturate();
    logic [3:0] s;
    logic [1:0] ec;
    logic       es;
    s = 4'b1011;
    mode_overlap = 1'b0;
    do_reset();
    for (int m = 0; m < 5; m++) begin
      for (int i = 0; i < 4; i++) step(1'b1, s[3-i], 1'b0);
      ec = (m < 2) ? 2'(m + 1) : 2'd3;
      es = (m >= 2);
      checks++; if (cnt_b !== ec) begin errs++; $display("FAIL sat_cnt match %0d got %0d want %0d", m, cnt_b, ec); end
      checks++; if (sat_b !== es) begin errs++; $display("FAIL sat_flag match %0d got %b want %b", m, sat_b, es); end
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    checks++; if (yb !== 1'b1)    begin errs++; $display("FAIL clr_y got %b want 1", yb); end
    checks++; if (cnt_b !== 2'd1) begin errs++; $display("FAIL clr_cnt got %0d want 1", cnt_b); end
    checks++; if (sat_b !== 1'b0) begin errs++; $display("FAIL clr_sat got %b want 0", sat_b); end
  endtask

  task automatic test_reset_mid();
    logic [6:0] s;
    s = 7'b1011101;
    mode_overlap = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, s[6-i], 1'b0);
    checks++; if (n_a !== 2'd3)   begin errs++; $display("FAIL mid_pre_n got %0d want 3", n_a); end
    checks++; if (cnt_a !== 8'd1) begin errs++; $display("FAIL mid_pre_cnt got %0d want 1", cnt_a); end
    @(negedge Clk_s);
    x_valid = 1'b1;
    x       = 1'b1;
    #1;
    checks++; if (y_a !== 1'b1) begin errs++; $display("FAIL mid_pend_y got %b want 1", y_a); end
    #2;
    Rst_s = 1'b1;
    #1;
    checks++; if (n_a !== 2'd0)   begin errs++; $display("FAIL mid_rst_n got %0d want 0", n_a); end
    checks++; if (cnt_a !== 8'd0) begin errs++; $display("FAIL mid_rst_cnt got %0d want 0", cnt_a); end
    checks++; if (y_a !== 1'b0)   begin errs++; $display("FAIL mid_rst_y got %b want 0", y_a); end
    checks++; if (d_a !== 2'd0)   begin errs++; $display("FAIL mid_rst_d got %0d want 0", d_a); end
    #2;
    Rst_s   = 1'b0;
    x_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++; if (ya !== 1'b0) begin errs++; $display("FAIL mid_post_y bit %0d got %b want 0", i, ya); end
    end
    checks++; if (n_a !== 2'd1) begin errs++; $display("FAIL mid_post_n got %0d want 1", n_a); end
  endtask

  task automatic test_len5();
    logic [7:0] s;
    logic       ey;
    s = 8'b11011011;
    mode_overlap = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, s[7-i], 1'b0);
      ey = (i == 4 || i == 7);
      checks++; if (yc !== ey) begin errs++; $display("FAIL len5_y bit %0d got %b want %b", i, yc, ey); end
    end
    checks++; if (cnt_c !== 8'd2) begin errs++; $display("FAIL len5_cnt got %0d want 2", cnt_c); end
    checks++; if (n_c !== 3'd2)   begin errs++; $display("FAIL len5_n got %0d want 2", n_c); end
  endtask

  initial begin
    test_reset();
    test_stream32();
    test_overlap();
    test_gaps();
    test_saturate();
    test_reset_mid();
    test_len5();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
